// File: rtl/four_phase_sequencer.sv
// Four-phase one-hot clock sequencer: latches config on start, then steps phases with
// programmable dwell, inter-phase gap, direction and round count (0 = free run until stop).
module four_phase_sequencer #(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned GAP_W   = 4,
    parameter int unsigned ROUND_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [DWELL_W-1:0] i_cfg_dwell,
    input  logic [GAP_W-1:0]   i_cfg_gap,
    input  logic               i_cfg_dir,
    input  logic [ROUND_W-1:0] i_cfg_rounds,
    input  logic               i_start,
    input  logic               i_stop,
    output logic               o_p0,
    output logic               o_p1,
    output logic               o_p2,
    output logic               o_p3,
    output logic [1:0]         o_phase_idx,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_t;

    state_t             r_state;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_dir;
    logic [ROUND_W-1:0] r_rounds;
    logic [ROUND_W-1:0] r_round_cnt;
    logic               r_stop_pend;
    logic [1:0]         r_idx;
    logic [3:0]         r_phase;
    logic               r_busy;
    logic               r_done;

    logic [1:0]         w_next_idx;
    logic [1:0]         w_first_idx;
    logic               w_last;
    logic [ROUND_W-1:0] w_round_next;
    logic               w_rounds_met;
    logic               w_dwell_done;
    logic [DWELL_W-1:0] w_dwell_one;

    assign w_dwell_one  = {{(DWELL_W-1){1'b0}}, 1'b1};
    assign w_next_idx   = r_dir ? r_idx - 2'd1 : r_idx + 2'd1;
    assign w_first_idx  = i_cfg_dir ? 2'd3 : 2'd0;
    assign w_last       = r_dir ? (r_idx == 2'd0) : (r_idx == 2'd3);
    // Round count saturates so a free run never wraps into a spurious match.
    assign w_round_next = !w_last ? r_round_cnt :
                          (&r_round_cnt) ? r_round_cnt : r_round_cnt + 1'b1;
    assign w_rounds_met = w_last && (r_rounds != '0) && (w_round_next == r_rounds);
    assign w_dwell_done = (r_dwell_cnt == r_dwell);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_dir       <= 1'b0;
            r_rounds    <= '0;
            r_round_cnt <= '0;
            r_stop_pend <= 1'b0;
            r_idx       <= 2'd0;
            r_phase     <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start && !i_stop) begin
                        r_state     <= StActive;
                        r_dwell     <= (i_cfg_dwell == '0) ? w_dwell_one : i_cfg_dwell;
                        r_gap       <= i_cfg_gap;
                        r_dir       <= i_cfg_dir;
                        r_rounds    <= i_cfg_rounds;
                        r_round_cnt <= '0;
                        r_stop_pend <= 1'b0;
                        r_idx       <= w_first_idx;
                        r_phase     <= 4'b0001 << w_first_idx;
                        r_dwell_cnt <= w_dwell_one;
                        r_busy      <= 1'b1;
                    end
                end
                StActive: begin
                    if (w_dwell_done) begin
                        r_round_cnt <= w_round_next;
                        if (w_rounds_met || r_stop_pend || i_stop) begin
                            r_state <= StIdle;
                            r_phase <= 4'b0000;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_gap != '0) begin
                            r_state   <= StGap;
                            r_phase   <= 4'b0000;
                            r_gap_cnt <= {{(GAP_W-1){1'b0}}, 1'b1};
                        end else begin
                            r_idx       <= w_next_idx;
                            r_phase     <= 4'b0001 << w_next_idx;
                            r_dwell_cnt <= w_dwell_one;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 1'b1;
                        if (i_stop) begin
                            r_stop_pend <= 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (i_stop || r_stop_pend) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_gap_cnt == r_gap) begin
                        r_state     <= StActive;
                        r_idx       <= w_next_idx;
                        r_phase     <= 4'b0001 << w_next_idx;
                        r_dwell_cnt <= w_dwell_one;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_p0        = r_phase[0];
    assign o_p1        = r_phase[1];
    assign o_p2        = r_phase[2];
    assign o_p3        = r_phase[3];
    assign o_phase_idx = r_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_four_phase_sequencer.sv
// Scoreboard bench for four_phase_sequencer: expected per-cycle outputs are queued at launch
// and popped on each falling edge; a monitor checks one-hot phases and single-cycle done.
module tb_four_phase_sequencer;

    logic        i_clk;
    logic        i_rst_n;
    logic [7:0]  i_cfg_dwell;
    logic [3:0]  i_cfg_gap;
    logic        i_cfg_dir;
    logic [15:0] i_cfg_rounds;
    logic        i_start;
    logic        i_stop;
    logic        o_p0, o_p1, o_p2, o_p3;
    logic [1:0]  o_phase_idx;
    logic        o_busy;
    logic        o_done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic        prev_done = 1'b0;
    logic        mon_en = 1'b0;

    four_phase_sequencer dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cfg_dwell  (i_cfg_dwell),
        .i_cfg_gap    (i_cfg_gap),
        .i_cfg_dir    (i_cfg_dir),
        .i_cfg_rounds (i_cfg_rounds),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .o_p0         (o_p0),
        .o_p1         (o_p1),
        .o_p2         (o_p2),
        .o_p3         (o_p3),
        .o_phase_idx  (o_phase_idx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] observed();
        return {o_p3, o_p2, o_p1, o_p0, o_phase_idx, o_busy, o_done};
    endfunction

    // Byte layout: {p3..p0, phase_idx, busy, done}.
    task automatic push_seq(input int dwell, input int gap, input bit dir, input int nphases,
                            input int tail_gap);
        int         d;
        logic [1:0] idx;
        logic [3:0] oh;
        d   = (dwell == 0) ? 1 : dwell;
        idx = 2'd0;
        for (int k = 0; k < nphases; k++) begin
            idx = dir ? 2'(3 - (k % 4)) : 2'(k % 4);
            oh  = 4'b0001 << idx;
            for (int j = 0; j < d; j++) exp_q.push_back({oh, idx, 1'b1, 1'b0});
            if (k != nphases - 1)
                for (int j = 0; j < gap; j++) exp_q.push_back({4'b0000, idx, 1'b1, 1'b0});
        end
        for (int j = 0; j < tail_gap; j++) exp_q.push_back({4'b0000, idx, 1'b1, 1'b0});
        exp_q.push_back({4'b0000, idx, 1'b0, 1'b1});
        exp_q.push_back({4'b0000, idx, 1'b0, 1'b0});
        exp_q.push_back({4'b0000, idx, 1'b0, 1'b0});
    endtask

    task automatic launch(input logic [7:0] dwell, input logic [3:0] gap, input bit dir,
                          input logic [15:0] rounds);
        @(negedge i_clk);
        i_cfg_dwell  = dwell;
        i_cfg_gap    = gap;
        i_cfg_dir    = dir;
        i_cfg_rounds = rounds;
        i_start      = 1'b1;
    endtask

    task automatic drain(input string tag, input int stop_at, input int restart_at,
                         input int abort_at);
        int c;
        c = 0;
        while (exp_q.size() != 0) begin
            @(negedge i_clk);
            c++;
            i_start = 1'b0;
            i_stop  = 1'b0;
            if (c == stop_at) i_stop = 1'b1;
            if (c == restart_at) begin
                i_start     = 1'b1;
                i_cfg_dwell = 8'd9;
                i_cfg_gap   = 4'd0;
            end
            check($sformatf("%s_c%0d", tag, c), {24'd0, observed()}, {24'd0, exp_q.pop_front()});
            if (c == abort_at) exp_q.delete();
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            check("onehot", {31'd0, ($countones({o_p3, o_p2, o_p1, o_p0}) <= 1)}, 32'd1);
            check("done_twice", {31'd0, prev_done & o_done}, 32'd0);
        end
        prev_done = o_done;
    end

    initial begin
        logic [1:0] last_idx;
        i_rst_n      = 1'b0;
        i_cfg_dwell  = 8'd0;
        i_cfg_gap    = 4'd0;
        i_cfg_dir    = 1'b0;
        i_cfg_rounds = 16'd0;
        i_start      = 1'b0;
        i_stop       = 1'b0;
        #12;
        check("reset_state", {24'd0, observed()}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;

        // Forward, single-cycle dwell, two rounds back to back.
        launch(8'd1, 4'd0, 1'b0, 16'd2);
        push_seq(1, 0, 1'b0, 8, 0);
        drain("fwd2", 0, 0, 0);

        // Reverse with gaps, one round.
        launch(8'd3, 4'd2, 1'b1, 16'd1);
        push_seq(3, 2, 1'b1, 4, 0);
        drain("rev_gap", 0, 0, 0);

        // Stop on second cycle of p1 in free run: p1 completes, p2 never asserts.
        launch(8'd4, 4'd0, 1'b0, 16'd0);
        push_seq(4, 0, 1'b0, 2, 0);
        drain("stop_act", 6, 0, 0);

        // Start with new config while busy must not disturb the running sequence.
        launch(8'd3, 4'd2, 1'b1, 16'd1);
        push_seq(3, 2, 1'b1, 4, 0);
        drain("restart_busy", 0, 5, 0);

        // Zero dwell behaves as one.
        launch(8'd0, 4'd1, 1'b1, 16'd1);
        push_seq(0, 1, 1'b1, 4, 0);
        drain("dwell0", 0, 0, 0);

        // Stop during a gap ends at the next edge.
        launch(8'd2, 4'd3, 1'b0, 16'd0);
        push_seq(2, 3, 1'b0, 1, 1);
        drain("stop_gap", 3, 0, 0);
        last_idx = 2'd0;

        // Start together with stop, and stop alone, are ignored in idle.
        launch(8'd1, 4'd0, 1'b0, 16'd1);
        i_stop = 1'b1;
        for (int j = 0; j < 3; j++) exp_q.push_back({4'b0000, last_idx, 1'b0, 1'b0});
        drain("idle_startstop", 0, 0, 0);
        @(negedge i_clk);
        i_stop = 1'b1;
        for (int j = 0; j < 3; j++) exp_q.push_back({4'b0000, last_idx, 1'b0, 1'b0});
        drain("idle_stop", 0, 0, 0);

        // Asynchronous reset mid-phase clears outputs without waiting for a clock edge.
        launch(8'd5, 4'd0, 1'b0, 16'd1);
        push_seq(5, 0, 1'b0, 4, 0);
        drain("pre_reset", 0, 0, 3);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset", {24'd0, observed()}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int j = 0; j < 4; j++) exp_q.push_back(8'h00);
        drain("post_reset", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
